// File: rtl/ysyx_23060077_if_id_queue_pkg.sv
// Shared predecode defines plus the types and constants used by the IF/ID queue.
`ifndef YSYX_23060077_IF_ID_DEFINES
`define YSYX_23060077_IF_ID_DEFINES
`define YSYX_23060077_PRE_OPT_WIDTH 6
`define YSYX_23060077_PRE_FENCE_I   0
`define YSYX_23060077_PRE_JAL       1
`define YSYX_23060077_PRE_JALR      2
`define YSYX_23060077_PRE_BRANCH    3
`define YSYX_23060077_PRE_ECALL     4
`define YSYX_23060077_PRE_MRET      5
`define YSYX_23060077_OPC_JAL       7'b1101111
`define YSYX_23060077_OPC_JALR      7'b1100111
`define YSYX_23060077_OPC_BRANCH    7'b1100011
`define YSYX_23060077_OPC_MISC_MEM  7'b0001111
`define YSYX_23060077_INST_ECALL    32'h0000_0073
`define YSYX_23060077_INST_MRET     32'h3020_0073
`endif

package ysyx_23060077_if_id_queue_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PRE_W     = `YSYX_23060077_PRE_OPT_WIDTH;
    localparam int unsigned PRE_FENCE_I = `YSYX_23060077_PRE_FENCE_I;
    localparam int unsigned PRE_JAL     = `YSYX_23060077_PRE_JAL;
    localparam int unsigned PRE_JALR    = `YSYX_23060077_PRE_JALR;
    localparam int unsigned PRE_BRANCH  = `YSYX_23060077_PRE_BRANCH;
    localparam int unsigned PRE_ECALL   = `YSYX_23060077_PRE_ECALL;
    localparam int unsigned PRE_MRET    = `YSYX_23060077_PRE_MRET;

    localparam logic [6:0]  OPC_JAL      = `YSYX_23060077_OPC_JAL;
    localparam logic [6:0]  OPC_JALR     = `YSYX_23060077_OPC_JALR;
    localparam logic [6:0]  OPC_BRANCH   = `YSYX_23060077_OPC_BRANCH;
    localparam logic [6:0]  OPC_MISC_MEM = `YSYX_23060077_OPC_MISC_MEM;
    localparam logic [31:0] INST_ECALL   = `YSYX_23060077_INST_ECALL;
    localparam logic [31:0] INST_MRET    = `YSYX_23060077_INST_MRET;

    typedef logic [PRE_W-1:0] predecode_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        predecode_t      pre;
    } if_id_entry_t;

endpackage

// File: rtl/ysyx_23060077_predecode.sv
// Combinational control-flow hints extracted from a raw instruction word.
module ysyx_23060077_predecode
    import ysyx_23060077_if_id_queue_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output logic [PRE_W-1:0] predecode
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        predecode              = '0;
        predecode[PRE_JAL]     = (opcode == OPC_JAL);
        predecode[PRE_JALR]    = (opcode == OPC_JALR) && (funct3 == 3'b000);
        predecode[PRE_BRANCH]  = (opcode == OPC_BRANCH);
        predecode[PRE_ECALL]   = (inst == INST_ECALL);
        predecode[PRE_MRET]    = (inst == INST_MRET);
        predecode[PRE_FENCE_I] = (opcode == OPC_MISC_MEM) && (funct3 == 3'b001);
    end

endmodule

// File: rtl/ysyx_23060077_if_id_queue.sv
// In-order fetch-to-decode buffer with input predecode and whole-queue flush on redirect.
module ysyx_23060077_if_id_queue
    import ysyx_23060077_if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       if_to_id_valid_i,
    output logic                       if_to_id_ready_o,
    input  logic [XLEN-1:0]            ifu_pc_i,
    input  logic [XLEN-1:0]            ifu_inst_i,
    output logic [PRE_W-1:0]           ifu_predecode_o,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [XLEN-1:0]            id_pc_o,
    output logic [XLEN-1:0]            id_inst_o,
    output logic [PRE_W-1:0]           id_predecode_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if_id_entry_t         entry_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 push;
    logic                 pop;

    ysyx_23060077_predecode u_predecode (
        .inst      (ifu_inst_i),
        .predecode (ifu_predecode_o)
    );

    // Ready and valid depend only on stored occupancy, never on id_ready_i.
    assign if_to_id_ready_o = (count_q != CNT_W'(DEPTH));
    assign id_valid_o       = (count_q != '0);
    assign push             = if_to_id_valid_i & if_to_id_ready_o & ~flush_i;
    assign pop              = id_valid_o & id_ready_i & ~flush_i;

    assign id_pc_o        = entry_q[rd_ptr_q].pc;
    assign id_inst_o      = entry_q[rd_ptr_q].inst;
    assign id_predecode_o = entry_q[rd_ptr_q].pre;
    assign count_o        = count_q;

    // Pointer and occupancy control; flush discards everything including this cycle's offers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; the predecode captured here is what decode later sees.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else if (push) begin
            entry_q[wr_ptr_q] <= '{pc: ifu_pc_i, inst: ifu_inst_i, pre: ifu_predecode_o};
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_if_id_queue.sv
// Directed bench for the IF/ID queue: handshake, ordering, predecode, flush and async reset.
module tb_ysyx_23060077_if_id_queue;
    import ysyx_23060077_if_id_queue_pkg::*;

    logic              clock;
    logic              reset;
    logic              flush_i;
    logic              if_to_id_valid_i;
    logic              if_to_id_ready_o;
    logic [31:0]       ifu_pc_i;
    logic [31:0]       ifu_inst_i;
    logic [PRE_W-1:0]  ifu_predecode_o;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [31:0]       id_pc_o;
    logic [31:0]       id_inst_o;
    logic [PRE_W-1:0]  id_predecode_o;
    logic [1:0]        count_o;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_23060077_if_id_queue #(.DEPTH(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush_i          (flush_i),
        .if_to_id_valid_i (if_to_id_valid_i),
        .if_to_id_ready_o (if_to_id_ready_o),
        .ifu_pc_i         (ifu_pc_i),
        .ifu_inst_i       (ifu_inst_i),
        .ifu_predecode_o  (ifu_predecode_o),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_pc_o          (id_pc_o),
        .id_inst_o        (id_inst_o),
        .id_predecode_o   (id_predecode_o),
        .count_o          (count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One active edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [31:0] pd_inst [7] = '{32'h0000_006F, 32'h0000_100F, 32'h3020_0073, 32'h0000_0073,
                                 32'h0000_8067, 32'h0000_0063, 32'h0000_1067};
    logic [5:0]  pd_exp  [7] = '{6'h02, 6'h01, 6'h20, 6'h10, 6'h04, 6'h08, 6'h00};
    logic [31:0] st_inst [2] = '{32'h0000_006F, 32'h0000_0013};
    logic [5:0]  st_pre  [2] = '{6'h02, 6'h00};

    initial begin
        reset = 1'b0; flush_i = 1'b0; if_to_id_valid_i = 1'b0; id_ready_i = 1'b0;
        ifu_pc_i = '0; ifu_inst_i = '0;
        #1;
        check("rst_valid", 64'(id_valid_o), 64'd0);
        check("rst_ready", 64'(if_to_id_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_pc", 64'(id_pc_o), 64'd0);
        check("rst_inst", 64'(id_inst_o), 64'd0);
        check("rst_pre", 64'(id_predecode_o), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Predecode with valid low
        for (int i = 0; i < 7; i++) begin
            ifu_inst_i = pd_inst[i];
            #1;
            check($sformatf("predecode_%0h", pd_inst[i]), 64'(ifu_predecode_o), 64'(pd_exp[i]));
        end
        step();
        check("no_push_when_invalid", 64'(count_o), 64'd0);

        // Single push, then fill, then refused third offer
        if_to_id_valid_i = 1'b1; ifu_pc_i = 32'h3000_0000; ifu_inst_i = 32'h0000_0013;
        step();
        check("single_valid", 64'(id_valid_o), 64'd1);
        check("single_pc", 64'(id_pc_o), 64'h3000_0000);
        check("single_count", 64'(count_o), 64'd1);
        check("single_pre", 64'(id_predecode_o), 64'd0);
        ifu_pc_i = 32'h3000_0004;
        step();
        check("full_count", 64'(count_o), 64'd2);
        check("full_ready", 64'(if_to_id_ready_o), 64'd0);
        ifu_pc_i = 32'h3000_0008;
        step();
        check("third_refused", 64'(count_o), 64'd2);
        if_to_id_valid_i = 1'b0; id_ready_i = 1'b1;
        #1;
        check("pop0_pc", 64'(id_pc_o), 64'h3000_0000);
        step();
        check("pop1_pc", 64'(id_pc_o), 64'h3000_0004);
        check("pop1_count", 64'(count_o), 64'd1);
        step();
        check("drained_valid", 64'(id_valid_o), 64'd0);
        check("drained_count", 64'(count_o), 64'd0);

        // Streaming with decoder always ready
        for (int i = 0; i < 8; i++) begin
            if_to_id_valid_i = 1'b1;
            ifu_pc_i   = 32'h4000_0000 + 32'(4 * i);
            ifu_inst_i = st_inst[i % 2];
            step();
            check($sformatf("stream_pc_%0d", i), 64'(id_pc_o), 64'h4000_0000 + 64'(4 * i));
            check($sformatf("stream_pre_%0d", i), 64'(id_predecode_o), 64'(st_pre[i % 2]));
            check($sformatf("stream_count_%0d", i), 64'(count_o), 64'd1);
        end
        if_to_id_valid_i = 1'b0;
        step();
        check("stream_empty", 64'(count_o), 64'd0);

        // Flush with a full queue and a simultaneous offer
        id_ready_i = 1'b0; if_to_id_valid_i = 1'b1; ifu_inst_i = 32'h0000_0013;
        ifu_pc_i = 32'h5000_0000; step();
        ifu_pc_i = 32'h5000_0004; step();
        check("pre_flush_count", 64'(count_o), 64'd2);
        flush_i = 1'b1; ifu_pc_i = 32'h5000_0008;
        step();
        check("flush_full_count", 64'(count_o), 64'd0);
        check("flush_full_valid", 64'(id_valid_o), 64'd0);
        check("flush_full_ready", 64'(if_to_id_ready_o), 64'd1);

        // Flush with one entry: the concurrent push must be dropped
        flush_i = 1'b0; ifu_pc_i = 32'h5000_0010;
        step();
        flush_i = 1'b1; ifu_pc_i = 32'h5000_0014;
        step();
        check("flush_push_count", 64'(count_o), 64'd0);
        flush_i = 1'b0; ifu_pc_i = 32'h6000_0000;
        step();
        check("post_flush_count", 64'(count_o), 64'd1);
        check("post_flush_pc", 64'(id_pc_o), 64'h6000_0000);
        if_to_id_valid_i = 1'b0; id_ready_i = 1'b1;
        step();
        check("post_flush_drain", 64'(count_o), 64'd0);

        // Asynchronous reset while holding two entries
        id_ready_i = 1'b0; if_to_id_valid_i = 1'b1;
        ifu_pc_i = 32'h7000_0000; step();
        ifu_pc_i = 32'h7000_0004; step();
        if_to_id_valid_i = 1'b0;
        check("pre_rst_count", 64'(count_o), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(id_valid_o), 64'd0);
        check("async_rst_ready", 64'(if_to_id_ready_o), 64'd1);
        check("async_rst_pc", 64'(id_pc_o), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("after_rst_count", 64'(count_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_if_id_queue.md
# ysyx_23060077_if_id_queue

Decoupling queue between the instruction fetch unit and the decode unit: it accepts fetched (pc, inst) pairs over the if_to_id valid/ready handshake, buffers up to DEPTH of them, and presents them in order to the decoder. It also predecodes the instruction on its input, producing the control-flow hints the fetch unit uses to pick its next PC and to forward fence.i to the instruction cache. A redirect from write-back flushes all buffered, wrong-path instructions.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- clock  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- flush_i  input  1  redirect from write-back; discard all entries
- if_to_id_valid_i  input  1  fetch presents pc/inst
- if_to_id_ready_o  output  1  queue can accept
- ifu_pc_i  input  32  fetched pc
- ifu_inst_i  input  32  fetched instruction
- ifu_predecode_o  output  `YSYX_23060077_PRE_OPT_WIDTH  combinational predecode of ifu_inst_i
- id_valid_o  output  1  head entry valid
- id_ready_i  input  1  decoder accepts head
- id_pc_o  output  32  head pc
- id_inst_o  output  32  head instruction
- id_predecode_o  output  `YSYX_23060077_PRE_OPT_WIDTH  stored predecode of head
- count_o  output  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH entries of {pc, inst, predecode}; wr_ptr and rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count tracks occupancy in the range 0..DEPTH.
- push = if_to_id_valid_i & if_to_id_ready_o & ~flush_i; pop = id_valid_o & id_ready_i & ~flush_i.
- if_to_id_ready_o = (count != DEPTH); it has no combinational path from id_ready_i.
- id_valid_o = (count != 0); the head fields are driven from entry rd_ptr.
- Push and pop in the same cycle: count is unchanged and both pointers advance. When full, ready is low, so simultaneous push/pop is impossible at full. When empty, pop is impossible.
- flush_i: count, wr_ptr and rd_ptr go to 0 on the next edge. A push or pop offered in the same cycle is dropped and has no effect.
- Predecode is computed from inst and is not gated by valid. The fetch unit holds its inst after the handshake and relies on the hint persisting. Bit definitions:
  - JAL: opcode 1101111
  - JALR: opcode 1100111, funct3 000
  - BRANCH: opcode 1100011
  - ECALL: inst == 0x00000073
  - MRET: inst == 0x30200073
  - FENCE_I: opcode 0001111, funct3 001
- id_predecode_o is the predecode value captured at push time.

## Timing
- Reset (reset low, asynchronous): count 0, pointers 0, id_valid_o 0, if_to_id_ready_o 1, and all entry fields 0, so id_pc_o, id_inst_o and id_predecode_o read 0.
- Latency: a push on edge N makes the entry visible on id_valid_o/id_pc_o after edge N; there is no same-cycle bypass.
- Throughput: one instruction per cycle sustained when id_ready_i stays high.
- Flush asserted at edge N: id_valid_o is 0 and if_to_id_ready_o is 1 after edge N. A push in cycle N+1 is accepted normally.
- Reset deasserting mid-stream: the queue restarts empty and nothing is replayed.

## Structure
- The shared define file holds:
  - `YSYX_23060077_PRE_OPT_WIDTH (6)
  - bit indices `YSYX_23060077_PRE_FENCE_I/JAL/JALR/BRANCH/ECALL/MRET
  - the opcode constants
- Sub-module ysyx_23060077_predecode: purely combinational, inst in, predecode out. It is instantiated once on ifu_inst_i; its output drives ifu_predecode_o and is stored on push.
- FIFO control (pointers, count, flush) stays in this module.

## Test plan
- Single push pc=0x3000_0000, inst=0x00000013 with id_ready_i=0 → after one edge id_valid_o=1, id_pc_o=0x3000_0000, count_o=1, id_predecode_o=0.
- Push 0x3000_0000 and 0x3000_0004 back-to-back with id_ready_i=0 → count_o=2 and if_to_id_ready_o=0. The third offer is not accepted. The decoder then pops in order 0x3000_0000 followed by 0x3000_0004.
- Continuous valid input with id_ready_i=1 for 8 cycles → 8 instructions delivered in order, count_o never exceeds 1, and the pointers wrap correctly.
- ifu_inst_i=0x0000006F (jal) with valid low → ifu_predecode_o has only JAL set. ifu_inst_i=0x0000100F → only FENCE_I set. 0x30200073 → only MRET set.
- Queue holding 2 entries with flush_i=1 and a simultaneous valid push → next cycle count_o=0 and id_valid_o=0; the pushed instruction is never delivered.
- Assert reset low asynchronously while count_o=2 → id_valid_o=0 and if_to_id_ready_o=1 immediately, without waiting for a clock edge.
